instruction_fetch: RTL and testbench

Fetch stage of the 16-bit MIPS16-style CPU. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register for the decode stage. It handles stalls, flushes and branch/jump redirects from the hazard and branch logic, and provides a halt/resume control for the board debug path.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 29 ++
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit MIPS16-style CPU pipeline.
package cpu_pkg;
  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSTR = 16'h0800;
  localparam word_t RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    word_t instr;
    word_t pc_plus1;
    logic  valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus1: '0, valid: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, load beats bubble.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t load_data,
  output if_id_t if_id
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id <= IF_ID_BUBBLE;
    end else if (flush) begin
      if_id <= IF_ID_BUBBLE;
    end else if (stall) begin
      if_id <= if_id;
    end else if (load) begin
      if_id <= load_data;
    end else if (bubble) begin
      if_id <= IF_ID_BUBBLE;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, BOOT/RUN/HALT control and the accepted-instruction count.
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              resume,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic [WORD_W-1:0] fetch_count,
  output logic              halted
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        count_q, count_d;
  word_t        pc_plus1;
  logic         halted_q;
  logic         fetch_load;
  logic         fetch_bubble;
  if_id_t       load_data;
  if_id_t       if_id;

  assign pc_plus1     = pc_q + WORD_W'(1);
  assign fetch_load   = (state_q == ST_RUN) && !flush && !stall;
  assign fetch_bubble = (state_q == ST_HALT);

  always_comb begin
    load_data.instr    = imem_data;
    load_data.pc_plus1 = pc_plus1;
    load_data.valid    = 1'b1;
  end

  // State register, PC and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  // Next state; redirect overrides the PC in every state but never moves the FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt && !redirect) state_d = ST_HALT;
        if (!stall) pc_d = pc_plus1;
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
    if (redirect) pc_d = redirect_pc;
    if (fetch_load) count_d = count_q + WORD_W'(1);
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .load      (fetch_load),
    .bubble    (fetch_bubble),
    .load_data (load_data),
    .if_id     (if_id)
  );

  assign imem_addr      = pc_q;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc_plus1 = if_id.pc_plus1;
  assign if_id_valid    = if_id.valid;
  assign fetch_count    = count_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a per-edge reference model of the fetch rules.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall, flush, redirect, halt, resume;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr, if_id_pc_plus1, fetch_count;
  logic        if_id_valid, halted;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode;
  logic [15:0] m_pc, m_instr, m_pp1, m_cnt;
  logic        m_valid;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .resume         (resume),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  // Memory image: word k holds 16'h1000 + k.
  assign imem_data = 16'h1000 + imem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    return 16'h1000 + addr;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode  = 0;
    m_pc    = 16'h0000;
    m_instr = 16'h0800;
    m_pp1   = 16'h0000;
    m_valid = 1'b0;
    m_cnt   = 16'h0000;
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc_plus1", if_id_pc_plus1, m_pp1);
    check("if_id_valid", 16'(if_id_valid), 16'(m_valid));
    check("fetch_count", fetch_count, m_cnt);
    check("halted", 16'(halted), (m_mode == 2) ? 16'd1 : 16'd0);
  endtask

  // One clock edge: predict from the current inputs, advance, then compare.
  task automatic tick();
    int          n_mode;
    logic [15:0] n_pc, n_instr, n_pp1, n_cnt;
    logic        n_valid;
    n_mode = m_mode; n_pc = m_pc; n_instr = m_instr;
    n_pp1 = m_pp1; n_valid = m_valid; n_cnt = m_cnt;
    if (rst) begin
      if (redirect) n_pc = redirect_pc;
      else if (m_mode == 1 && !stall) n_pc = m_pc + 16'd1;
      if (flush) begin
        n_instr = 16'h0800; n_pp1 = 16'h0000; n_valid = 1'b0;
      end else if (stall) begin
        n_instr = m_instr;
      end else if (m_mode == 1) begin
        n_instr = mem_word(m_pc); n_pp1 = m_pc + 16'd1; n_valid = 1'b1;
        n_cnt = m_cnt + 16'd1;
      end else if (m_mode == 2) begin
        n_instr = 16'h0800; n_pp1 = 16'h0000; n_valid = 1'b0;
      end
      if (m_mode == 0) n_mode = 1;
      else if (m_mode == 1 && halt && !redirect) n_mode = 2;
      else if (m_mode == 2 && resume) n_mode = 1;
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_instr = n_instr;
    m_pp1 = n_pp1; m_valid = n_valid; m_cnt = n_cnt;
    compare_all();
  endtask

  initial begin
    rst = 1'b0;
    stall = 0; flush = 0; redirect = 0; halt = 0; resume = 0;
    redirect_pc = 16'h0000;
    m_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_pc", imem_addr, 16'h0000);
    check("rst_instr", if_id_instr, 16'h0800);
    check("rst_valid", 16'(if_id_valid), 16'd0);
    check("rst_count", fetch_count, 16'd0);
    rst = 1'b1;

    // Boot edge, then first fetch of RESET_PC
    tick();
    check("boot_valid", 16'(if_id_valid), 16'd0);
    tick();
    check("first_instr", if_id_instr, 16'h1000);
    check("first_pp1", if_id_pc_plus1, 16'h0001);
    check("first_valid", 16'(if_id_valid), 16'd1);
    repeat (5) tick();
    check("run_pc", imem_addr, 16'h0006);
    check("run_count", fetch_count, 16'h0006);

    // Redirect to 3 without flush (word 6 enters as delay slot), then stall at PC=4
    redirect = 1; redirect_pc = 16'h0003;
    tick();
    redirect = 0;
    tick();
    stall = 1;
    repeat (3) tick();
    check("stall_pc", imem_addr, 16'h0004);
    check("stall_instr", if_id_instr, 16'h1003);
    check("stall_count", fetch_count, 16'h0008);
    stall = 0;
    tick();
    check("unstall_instr", if_id_instr, 16'h1004);

    // Redirect + stall + flush at PC=8
    repeat (3) tick();
    check("pre_redirect_pc", imem_addr, 16'h0008);
    redirect = 1; redirect_pc = 16'h0040; stall = 1; flush = 1;
    tick();
    redirect = 0; stall = 0; flush = 0;
    check("flush_pc", imem_addr, 16'h0040);
    check("flush_instr", if_id_instr, 16'h0800);
    check("flush_valid", 16'(if_id_valid), 16'd0);
    tick();
    check("target_instr", if_id_instr, 16'h1040);

    // PC wrap-around
    redirect = 1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 0;
    tick();
    check("wrap_pp1", if_id_pc_plus1, 16'h0000);
    check("wrap_instr", if_id_instr, 16'h0FFF);
    tick();
    check("wrap_pc", imem_addr, 16'h0001);

    // Halt at PC=10, drain, halt+resume, resume at 11
    redirect = 1; redirect_pc = 16'h000A;
    tick();
    redirect = 0; halt = 1;
    tick();
    halt = 0;
    check("halt_flag", 16'(halted), 16'd1);
    check("halt_pc", imem_addr, 16'h000B);
    check("halt_edge_instr", if_id_instr, 16'h100A);
    repeat (2) tick();
    check("halt_valid", 16'(if_id_valid), 16'd0);
    check("halt_hold_pc", imem_addr, 16'h000B);
    halt = 1; resume = 1;
    tick();
    halt = 0; resume = 0;
    check("resume_flag", 16'(halted), 16'd0);
    tick();
    check("resume_instr", if_id_instr, 16'h100B);
    check("resume_pc", imem_addr, 16'h000C);

    // Halt together with redirect: redirect taken, halt ignored
    halt = 1; redirect = 1; redirect_pc = 16'h0020;
    tick();
    halt = 0; redirect = 0;
    check("halt_redir_flag", 16'(halted), 16'd0);
    check("halt_redir_pc", imem_addr, 16'h0020);
    tick();
    check("halt_redir_instr", if_id_instr, 16'h1020);

    // Asynchronous reset mid-cycle while a redirect is pending
    redirect = 1; redirect_pc = 16'h0077;
    #3;
    rst = 1'b0;
    #1;
    m_reset();
    compare_all();
    check("async_pc", imem_addr, 16'h0000);
    check("async_valid", 16'(if_id_valid), 16'd0);
    check("async_count", fetch_count, 16'd0);
    tick();
    rst = 1'b1; redirect = 0;
    tick();
    check("reboot_valid", 16'(if_id_valid), 16'd0);
    check("reboot_pc", imem_addr, 16'h0000);
    tick();
    check("reboot_instr", if_id_instr, 16'h1000);
    check("reboot_count", fetch_count, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
